// File: rtl/dram_read_scheduler.sv
// Round-robin DRAM chunk-read scheduler: one playback pointer per instrument,
// credit-limited in-flight chunks, registered valid/ready request port.
module dram_read_scheduler #(
    parameter int unsigned INSTRUMENT_COUNT = 8,
    parameter int unsigned MAX_OUTSTANDING  = 4,
    localparam int unsigned IW = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INSTRUMENT_COUNT:0][23:0]    addr_starts,
    input  logic [INSTRUMENT_COUNT-1:0]        trigger,
    input  logic [INSTRUMENT_COUNT-1:0]        chunk_done,
    output logic                               req_valid,
    input  logic                               req_ready,
    output logic [23:0]                        req_addr,
    output logic [IW-1:0]                      req_instr,
    output logic [INSTRUMENT_COUNT-1:0]        active
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } play_st_t;

    play_st_t    st     [INSTRUMENT_COUNT];
    logic [23:0] ptr    [INSTRUMENT_COUNT];
    logic [3:0]  credit [INSTRUMENT_COUNT];

    logic [IW-1:0]               last_grant;
    logic [INSTRUMENT_COUNT-1:0] eligible;
    logic                        arb_en;
    logic                        grant_valid;
    logic [IW-1:0]               grant;

    // Arbitrate when the port is empty or its request is being accepted this cycle.
    assign arb_en = !req_valid || req_ready;

    always_comb begin
        for (int unsigned i = 0; i < INSTRUMENT_COUNT; i++) begin
            eligible[i] = (st[i] == PLAY) && (credit[i] < 4'(MAX_OUTSTANDING));
        end
    end

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= INSTRUMENT_COUNT; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= INSTRUMENT_COUNT) begin
                idx = idx - INSTRUMENT_COUNT;
            end
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant       = IW'(idx);
            end
        end
    end

    for (genvar i = 0; i < INSTRUMENT_COUNT; i++) begin : g_inst
        logic granted;
        logic trig_ok;
        logic done_ok;

        assign granted = arb_en && grant_valid && (grant == IW'(i));
        assign trig_ok = trigger[i] && (addr_starts[i] < addr_starts[i+1]);
        assign done_ok = chunk_done[i] && (credit[i] != 4'd0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st[i]     <= IDLE;
                ptr[i]    <= '0;
                credit[i] <= '0;
            end else begin
                // A trigger overrides the pointer advance of a same-cycle grant.
                if (trig_ok) begin
                    ptr[i] <= addr_starts[i];
                    st[i]  <= PLAY;
                end else if (granted) begin
                    ptr[i] <= ptr[i] + 24'd1;
                    if (ptr[i] + 24'd1 == addr_starts[i+1]) begin
                        st[i] <= IDLE;
                    end
                end
                case ({granted, done_ok})
                    2'b10:   credit[i] <= credit[i] + 4'd1;
                    2'b01:   credit[i] <= credit[i] - 4'd1;
                    default: credit[i] <= credit[i];
                endcase
            end
        end

        assign active[i] = (st[i] == PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid  <= 1'b0;
            req_addr   <= '0;
            req_instr  <= '0;
            last_grant <= IW'(INSTRUMENT_COUNT - 1);
        end else if (arb_en) begin
            req_valid <= grant_valid;
            if (grant_valid) begin
                req_addr   <= ptr[grant];
                req_instr  <= grant;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_dram_read_scheduler.sv
// Directed self-checking bench for dram_read_scheduler (8 instruments, 4 credits).
module tb_dram_read_scheduler;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N:0][23:0]    addr_starts;
    logic [N-1:0]        trigger;
    logic [N-1:0]        chunk_done;
    logic                req_valid;
    logic                req_ready;
    logic [23:0]         req_addr;
    logic [IW-1:0]       req_instr;
    logic [N-1:0]        active;

    int total = 0;
    int bad   = 0;

    dram_read_scheduler #(
        .INSTRUMENT_COUNT (N),
        .MAX_OUTSTANDING  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_starts (addr_starts),
        .trigger     (trigger),
        .chunk_done  (chunk_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_instr   (req_instr),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        trigger    = '0;
        chunk_done = '0;
        req_ready  = 1'b0;
        rst        = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Region 0 = [0,e0), region 1 = [e0,e1), region 2 = [e1,e2), rest empty at e2.
    task automatic set_regions(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
        addr_starts    = '0;
        addr_starts[1] = e0;
        addr_starts[2] = e1;
        for (int k = 3; k <= N; k++) addr_starts[k] = e2;
    endtask

    initial begin
        int exp_i [6];
        int exp_a [6];
        addr_starts = '0;
        trigger     = '0;
        chunk_done  = '0;
        req_ready   = 1'b0;
        #2;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(req_valid), 0);
        chk("rst_addr",  32'(req_addr),  0);
        chk("rst_instr", 32'(req_instr), 0);
        chk("rst_active", 32'(active),   0);

        // Test 1: three-chunk region, last chunk issued, then idle
        set_regions(3, 3, 3);
        req_ready = 1'b1;
        trigger   = 8'h01;
        step();
        trigger = '0;
        chk("t1_active_on", 32'(active), 32'h01);
        chk("t1_no_req_yet", 32'(req_valid), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_valid", 32'(req_valid), 1);
            chk("t1_addr",  32'(req_addr),  32'(k));
            chk("t1_instr", 32'(req_instr), 0);
        end
        chk("t1_active_off", 32'(active), 0);
        step();
        chk("t1_no_4th", 32'(req_valid), 0);

        // Test 2: round robin across three instruments
        do_reset();
        set_regions(10, 20, 30);
        req_ready = 1'b1;
        trigger   = 8'h07;
        step();
        trigger = '0;
        exp_i = '{0, 1, 2, 0, 1, 2};
        exp_a = '{0, 10, 20, 1, 11, 21};
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t2_valid", 32'(req_valid), 1);
            chk("t2_instr", 32'(req_instr), 32'(exp_i[k]));
            chk("t2_addr",  32'(req_addr),  32'(exp_a[k]));
        end

        // Test 3: credit limit of 4, then one returned credit
        do_reset();
        set_regions(10, 10, 10);
        req_ready = 1'b1;
        trigger   = 8'h01;
        step();
        trigger = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_valid", 32'(req_valid), 1);
            chk("t3_addr",  32'(req_addr),  32'(k));
        end
        step();
        chk("t3_throttled", 32'(req_valid), 0);
        step();
        chk("t3_still_throttled", 32'(req_valid), 0);
        chunk_done = 8'h01;
        step();
        chunk_done = '0;
        chk("t3_credit_back_lat", 32'(req_valid), 0);
        step();
        chk("t3_extra_valid", 32'(req_valid), 1);
        chk("t3_extra_addr",  32'(req_addr),  4);
        step();
        chk("t3_only_one_more", 32'(req_valid), 0);

        // Test 4: stall holds request stable; other trigger mid-stall
        do_reset();
        set_regions(10, 20, 20);
        req_ready = 1'b0;
        trigger   = 8'h01;
        step();
        trigger = '0;
        step();
        chk("t4_valid", 32'(req_valid), 1);
        chk("t4_addr",  32'(req_addr),  0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) trigger = 8'h02;
            step();
            trigger = '0;
            chk("t4_stall_valid", 32'(req_valid), 1);
            chk("t4_stall_addr",  32'(req_addr),  0);
            chk("t4_stall_instr", 32'(req_instr), 0);
        end
        chk("t4_both_active", 32'(active), 32'h03);
        req_ready = 1'b1;
        step();
        chk("t4_next_instr", 32'(req_instr), 1);
        chk("t4_next_addr",  32'(req_addr),  10);

        // Test 5: retrigger at ptr=5 coincident with a grant
        do_reset();
        set_regions(20, 20, 20);
        req_ready  = 1'b1;
        chunk_done = 8'h01;
        trigger    = 8'h01;
        step();
        trigger = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_addr", 32'(req_addr), 32'(k));
        end
        trigger = 8'h01;
        step();
        trigger = '0;
        chk("t5_old_ptr_issued", 32'(req_addr), 5);
        step();
        chk("t5_restart_addr", 32'(req_addr), 0);
        step();
        chk("t5_restart_next", 32'(req_addr), 1);
        chunk_done = '0;

        // Empty region trigger is ignored
        do_reset();
        set_regions(20, 20, 20);
        req_ready = 1'b1;
        trigger   = 8'h08;
        step();
        trigger = '0;
        chk("t5_empty_active", 32'(active), 0);
        step();
        chk("t5_empty_noreq", 32'(req_valid), 0);

        // Test 6: asynchronous reset mid-transfer
        do_reset();
        set_regions(20, 20, 20);
        req_ready = 1'b1;
        trigger   = 8'h01;
        step();
        trigger = '0;
        step();
        step();
        step();
        chk("t6_pre_addr", 32'(req_addr), 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid",  32'(req_valid), 0);
        chk("t6_rst_addr",   32'(req_addr),  0);
        chk("t6_rst_active", 32'(active),    0);
        step();
        rst     = 1'b0;
        trigger = 8'h01;
        step();
        trigger = '0;
        step();
        chk("t6_post_valid", 32'(req_valid), 1);
        chk("t6_post_addr",  32'(req_addr),  0);
        chk("t6_post_instr", 32'(req_instr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
